pwm_rgb_buzzer: RTL and testbench

- Downstream consumer of the FlexBus peripheral register block (perip_flexbus).
- Takes its LED_FREQ, BZ_FREQ and LEDR/LEDG/LEDB duty outputs and produces three RGB LED PWM pins, a buzzer square wave and a period-boundary tick.
- Register values are shadowed and applied only at period boundaries, so bus writes never glitch the outputs.

---
 rtl/pwm_rgb_buzzer.sv | 115 +++++++++++
 tb/tb_pwm_rgb_buzzer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwm_rgb_buzzer.sv
// RGB LED PWM and buzzer square-wave generator fed by the FlexBus register block.
// Register values are shadowed and only take effect at period/half-period boundaries.
module pwm_rgb_buzzer #(
  parameter int CNT_W          = 32,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [CNT_W-1:0] LED_FREQ_Qin,
  input  logic [CNT_W-1:0] LEDR_Puty_Qin,
  input  logic [CNT_W-1:0] LEDG_Puty_Qin,
  input  logic [CNT_W-1:0] LEDB_Puty_Qin,
  input  logic [CNT_W-1:0] BZ_FREQ_Qin,
  output logic             LED_R,
  output logic             LED_G,
  output logic             LED_B,
  output logic             BZ,
  output logic             PERIOD_TICK
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] dr_q, dr_d;
  logic [CNT_W-1:0] dg_q, dg_d;
  logic [CNT_W-1:0] db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       led_q, led_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] bh_q, bh_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             bz_q, bz_d;

  logic led_wrap;
  logic led_reload;
  logic bz_toggle;

  always_comb begin
    led_wrap   = (per_q != '0) && (cnt_q == per_q - ONE);
    led_reload = (per_q == '0) || led_wrap;
    bz_toggle  = (bh_q != '0) && (bcnt_q == bh_q - ONE);

    per_d  = per_q;
    dr_d   = dr_q;
    dg_d   = dg_q;
    db_d   = db_q;
    cnt_d  = cnt_q;
    led_d  = 3'b000;
    tick_d = led_wrap;
    bh_d   = bh_q;
    bcnt_d = bcnt_q;
    bz_d   = bz_q;

    if (led_reload) begin
      per_d = LED_FREQ_Qin;
      dr_d  = LEDR_Puty_Qin;
      dg_d  = LEDG_Puty_Qin;
      db_d  = LEDB_Puty_Qin;
    end

    // Outputs are computed from the shadows in force for the current count,
    // so a period always completes with the values it started with.
    if (per_q == '0) begin
      cnt_d = '0;
    end else begin
      cnt_d = led_wrap ? '0 : cnt_q + ONE;
      led_d = {cnt_q < db_q, cnt_q < dg_q, cnt_q < dr_q};
    end

    if (bh_q == '0) begin
      bcnt_d = '0;
      bz_d   = 1'b0;
      bh_d   = BZ_FREQ_Qin;
    end else if (bz_toggle) begin
      bcnt_d = '0;
      bz_d   = ~bz_q;
      bh_d   = BZ_FREQ_Qin;
    end else begin
      bcnt_d = bcnt_q + ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      per_q  <= '0;
      dr_q   <= '0;
      dg_q   <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
      led_q  <= 3'b000;
      tick_q <= 1'b0;
      bh_q   <= '0;
      bcnt_q <= '0;
      bz_q   <= 1'b0;
    end else begin
      per_q  <= per_d;
      dr_q   <= dr_d;
      dg_q   <= dg_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      bh_q   <= bh_d;
      bcnt_q <= bcnt_d;
      bz_q   <= bz_d;
    end
  end

  assign LED_R       = led_q[0] ^ LED_ACTIVE_LOW;
  assign LED_G       = led_q[1] ^ LED_ACTIVE_LOW;
  assign LED_B       = led_q[2] ^ LED_ACTIVE_LOW;
  assign BZ          = bz_q;
  assign PERIOD_TICK = tick_q;

endmodule

// File: tb/tb_pwm_rgb_buzzer.sv
// Directed bench for pwm_rgb_buzzer: an active-high instance and an active-low
// instance share the same inputs; expected levels are hand-derived per edge.
module tb_pwm_rgb_buzzer;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [31:0] per = '0, dr = '0, dg = '0, db = '0, bh = '0;

  logic led_r, led_g, led_b, bz, tick;
  logic al_r, al_g, al_b, al_bz, al_tick;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pwm_rgb_buzzer #(.CNT_W(32), .LED_ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .LED_FREQ_Qin(per), .LEDR_Puty_Qin(dr), .LEDG_Puty_Qin(dg),
    .LEDB_Puty_Qin(db), .BZ_FREQ_Qin(bh),
    .LED_R(led_r), .LED_G(led_g), .LED_B(led_b), .BZ(bz), .PERIOD_TICK(tick)
  );

  pwm_rgb_buzzer #(.CNT_W(32), .LED_ACTIVE_LOW(1'b1)) dut_al (
    .CLK(CLK), .RST_n(RST_n),
    .LED_FREQ_Qin(per), .LEDR_Puty_Qin(dr), .LEDG_Puty_Qin(dg),
    .LEDB_Puty_Qin(db), .BZ_FREQ_Qin(bh),
    .LED_R(al_r), .LED_G(al_g), .LED_B(al_b), .BZ(al_bz), .PERIOD_TICK(al_tick)
  );

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset-release sequence with P=10, DR=3, DG=0, DB=10 held. k is the edge
  // index after release; the buzzer half-period is bh_exp (0 or 2).
  task automatic run_s1(input string tag, input int bh_exp);
    for (int k = 0; k < 30; k++) begin
      step();
      chk({tag, "_r"},    k, led_r, (k >= 1) && (((k - 1) % 10) < 3));
      chk({tag, "_g"},    k, led_g, 1'b0);
      chk({tag, "_b"},    k, led_b, k >= 1);
      chk({tag, "_tick"}, k, tick,  (k >= 10) && (k % 10 == 0));
      if (bh_exp == 2) chk({tag, "_bz"}, k, bz, ((k / 2) % 2) == 1);
      else             chk({tag, "_bz"}, k, bz, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    per = 32'd10; dr = 32'd3; dg = 32'd0; db = 32'd10; bh = 32'd0;
    step();
    step();
    chk("rst_r", 0, led_r, 1'b0);
    chk("rst_g", 0, led_g, 1'b0);
    chk("rst_b", 0, led_b, 1'b0);
    chk("rst_bz", 0, bz, 1'b0);
    chk("rst_tick", 0, tick, 1'b0);
    chk("rst_al_r", 0, al_r, 1'b1);
    chk("rst_al_bz", 0, al_bz, 1'b0);

    // Scenario 1: static P=10, DR=3, DG=0, DB=10 (edges E0..E29)
    RST_n = 1'b1;
    run_s1("s1", 0);

    // Scenario 2: DR=15 >= P loaded at E30; constant high from E31
    dr = 32'd15;
    for (int k = 30; k <= 50; k++) begin
      step();
      if (k >= 31) begin
        chk("s2_r", k, led_r, 1'b1);
        chk("s2_al_r", k, al_r, 1'b0);
        chk("s2_al_g", k, al_g, 1'b1);
        chk("s2_al_b", k, al_b, 1'b0);
      end
    end

    // Scenario 3: DR=3 loaded at E60, DR=7 written at cycle 4, loaded at E70
    dr = 32'd3;
    for (int k = 51; k <= 84; k++) begin
      int d;
      step();
      d = (k <= 60) ? 15 : (k <= 70) ? 3 : 7;
      chk("s3_r", k, led_r, ((k - 1) % 10) < d);
      chk("s3_tick", k, tick, (k % 10) == 0);
      if (k == 64) dr = 32'd7;
    end

    // Scenario 4: P=0 written mid-period; period ends at E90, then idle
    per = 32'd0;
    for (int k = 85; k <= 100; k++) begin
      step();
      if (k <= 90) begin
        chk("s4_r", k, led_r, ((k - 1) % 10) < 7);
        chk("s4_b", k, led_b, 1'b1);
      end else begin
        chk("s4_r_idle", k, led_r, 1'b0);
        chk("s4_b_idle", k, led_b, 1'b0);
      end
      chk("s4_tick", k, tick, k == 90);
    end
    // P=4 resumes: load at E101, LEDs up at E102, wraps at E105, E109
    per = 32'd4;
    for (int k = 101; k <= 110; k++) begin
      step();
      chk("s4_resume_r", k, led_r, k >= 102);
      chk("s4_resume_b", k, led_b, k >= 102);
      chk("s4_resume_tick", k, tick, (k >= 105) && ((k - 105) % 4 == 0));
    end
    // P=1 loaded at the E113 wrap: tick every cycle afterwards
    per = 32'd1;
    for (int k = 111; k <= 118; k++) begin
      step();
      chk("s4_p1_tick", k, tick, k >= 113);
      chk("s4_p1_r", k, led_r, 1'b1);
    end

    // Scenario 5: buzzer H=4 (load E119), H=2 after next toggle, then H=0
    bh = 32'd4;
    for (int k = 119; k <= 126; k++) begin
      step();
      chk("s5_h4", k, bz, (((k - 119) / 4) % 2) == 1);
      chk("s5_al_bz", k, al_bz, (((k - 119) / 4) % 2) == 1);
      if (k == 124) bh = 32'd2;
    end
    for (int k = 127; k <= 138; k++) begin
      step();
      if (k <= 133) chk("s5_h2", k, bz, (((k - 127) / 2) % 2) == 1);
      else          chk("s5_h0", k, bz, 1'b0);
      if (k == 132) bh = 32'd0;
    end

    // Scenario 6: async reset with LED_R=1 and BZ=1
    per = 32'd10; dr = 32'd3; dg = 32'd0; db = 32'd10; bh = 32'd2;
    step();
    step();
    step();
    chk("s6_pre_r", 141, led_r, 1'b1);
    chk("s6_pre_bz", 141, bz, 1'b1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("s6_async_r", 141, led_r, 1'b0);
    chk("s6_async_b", 141, led_b, 1'b0);
    chk("s6_async_bz", 141, bz, 1'b0);
    chk("s6_async_tick", 141, tick, 1'b0);
    chk("s6_async_al_r", 141, al_r, 1'b1);
    step();
    step();
    chk("s6_hold_r", 0, led_r, 1'b0);
    chk("s6_hold_bz", 0, bz, 1'b0);
    RST_n = 1'b1;
    run_s1("s6", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
